// File: rtl/mult16_seq_ctrl_if.sv
// Request/result bundle for the sequential 16x16 multiplier.
// The ovf signal exists only when MULT_OVF_EN is defined.
interface mult16_seq_ctrl_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;
`ifdef MULT_OVF_EN
    logic        ovf;

    modport master (output start, a, b, input busy, done, p, ovf);
    modport slave  (input start, a, b, output busy, done, p, ovf);
`else
    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);
`endif
endinterface

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier sharing one 16-bit adder.
// Optional MULT_OVF_EN adds an ovf flag for products wider than 16 bits.
module mult16_seq_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    mult16_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [15:0] m;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [4:0]  cnt;
    logic [15:0] addend;
    logic [15:0] sum;
    logic        carry;
    logic        accept;
    logic [31:0] shifted;

    assign accept  = bus.start && ((state == IDLE) || (state == DONE));
    assign addend  = lo[0] ? m : 16'h0000;
    assign shifted = {carry, sum, lo[15:1]};

    unsigned_add adder (
        .A   (hi),
        .B   (addend),
        .Cin (1'b0),
        .SUM (sum),
        .C   (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = RUN;
            RUN:     if (cnt == 5'd15) stateNext = DONE;
            DONE:    stateNext = bus.start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // The carry rides into bit 31 of the shifted pair so 0xFFFF*0xFFFF is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= 16'h0000;
            hi    <= 16'h0000;
            lo    <= 16'h0000;
            cnt   <= 5'd0;
            bus.p <= 32'h0000_0000;
        end else if (accept) begin
            m   <= bus.a;
            hi  <= 16'h0000;
            lo  <= bus.b;
            cnt <= 5'd0;
        end else if (state == RUN) begin
            {hi, lo} <= shifted;
            cnt      <= cnt + 5'd1;
            if (cnt == 5'd15) begin
                bus.p <= shifted;
            end
        end
    end

`ifdef MULT_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf <= 1'b0;
        end else if ((state == RUN) && (cnt == 5'd15) && !accept) begin
            bus.ovf <= |shifted[31:16];
        end
    end
`endif

endmodule

// 16-bit unsigned adder with carry-in and carry-out.
module unsigned_add (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] SUM,
    output logic        C
);
    assign {C, SUM} = {1'b0, A} + {1'b0, B} + {16'h0000, Cin};
endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed self-checking bench for mult16_seq_ctrl; ovf checks only under MULT_OVF_EN.
module tb_mult16_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;

    mult16_seq_ctrl_if bus ();

    mult16_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1ns after the accepting edge with start dropped.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int cycles, output int busyCycles,
                            output bit timedOut);
        cycles     = 0;
        busyCycles = 0;
        while (bus.done !== 1'b1 && cycles < limit) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(posedge clk); #1;
            cycles++;
        end
        timedOut = (bus.done !== 1'b1);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        rst_n     = 1'b0;
        #12;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        else passCount++;
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
        else passCount++;
        checkCount++;
        if (bus.p !== 32'h0) $display("[TB] FAIL reset_p: got %h expected 00000000", bus.p);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (bus.ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf);
        else passCount++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cycles, busyCycles;
        bit timedOut;
        applyStimulus(16'h0003, 16'h0005);
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut) $display("[TB] FAIL basic_timeout: no done within 40 cycles");
        else passCount++;
        checkCount++;
        if (busyCycles != 16) $display("[TB] FAIL basic_busy_len: got %0d expected 16", busyCycles);
        else passCount++;
        checkCount++;
        if (bus.p !== 32'h0000_000F) $display("[TB] FAIL basic_p: got %h expected 0000000f", bus.p);
        else passCount++;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL basic_busy_at_done: got %b expected 0", bus.busy);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (bus.ovf !== 1'b0) $display("[TB] FAIL basic_ovf: got %b expected 0", bus.ovf);
        else passCount++;
`endif
        @(posedge clk); #1;
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL basic_done_width: got %b expected 0", bus.done);
        else passCount++;
    endtask

    task automatic test_zero();
        int cycles, busyCycles;
        bit timedOut;
        applyStimulus(16'h0000, 16'hABCD);
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut || busyCycles != 16)
            $display("[TB] FAIL zero_busy_len: got %0d expected 16", busyCycles);
        else passCount++;
        checkCount++;
        if (bus.p !== 32'h0) $display("[TB] FAIL zero_p: got %h expected 00000000", bus.p);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (bus.ovf !== 1'b0) $display("[TB] FAIL zero_ovf: got %b expected 0", bus.ovf);
        else passCount++;
`endif
    endtask

    task automatic test_carry();
        int cycles, busyCycles;
        bit timedOut;
        applyStimulus(16'hFFFF, 16'hFFFF);
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut) $display("[TB] FAIL carry_timeout: no done within 40 cycles");
        else passCount++;
        checkCount++;
        if (bus.p !== 32'hFFFE_0001) $display("[TB] FAIL carry_p: got %h expected fffe0001", bus.p);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (bus.ovf !== 1'b1) $display("[TB] FAIL carry_ovf: got %b expected 1", bus.ovf);
        else passCount++;
`endif
    endtask

    task automatic test_reset_midrun();
        int cycles, busyCycles;
        bit timedOut;
        int sawDone;
        applyStimulus(16'h1234, 16'h5678);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL midrun_busy: got %b expected 0", bus.busy);
        else passCount++;
        checkCount++;
        if (bus.p !== 32'h0) $display("[TB] FAIL midrun_p: got %h expected 00000000", bus.p);
        else passCount++;
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL midrun_done: got %b expected 0", bus.done);
        else passCount++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone++;
        end
        checkCount++;
        if (sawDone != 0) $display("[TB] FAIL midrun_no_done: got %0d active cycles expected 0", sawDone);
        else passCount++;
        applyStimulus(16'h0003, 16'h0005);
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut || bus.p !== 32'h0000_000F)
            $display("[TB] FAIL midrun_after_p: got %h expected 0000000f", bus.p);
        else passCount++;
    endtask

    task automatic test_start_busy();
        int cycles, busyCycles;
        bit timedOut;
        int sawBusy;
        applyStimulus(16'h0100, 16'h0100);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut || cycles != 11)
            $display("[TB] FAIL busy_start_latency: got %0d expected 11", cycles);
        else passCount++;
        checkCount++;
        if (bus.p !== 32'h0001_0000) $display("[TB] FAIL busy_start_p: got %h expected 00010000", bus.p);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (bus.ovf !== 1'b1) $display("[TB] FAIL busy_start_ovf: got %b expected 1", bus.ovf);
        else passCount++;
`endif
        sawBusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) sawBusy++;
        end
        checkCount++;
        if (sawBusy != 0) $display("[TB] FAIL busy_start_queued: got %0d busy cycles expected 0", sawBusy);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int cycles, busyCycles;
        bit timedOut;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 16'h0002;
        bus.b     = 16'h0007;
        @(posedge clk); #1;
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut || bus.p !== 32'h0000_000E)
            $display("[TB] FAIL b2b_first_p: got %h expected 0000000e", bus.p);
        else passCount++;
        bus.a = 16'h8000;
        bus.b = 16'h0002;
        @(posedge clk); #1;
        checkCount++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
        else passCount++;
        bus.start = 1'b0;
        waitDone(40, cycles, busyCycles, timedOut);
        checkCount++;
        if (timedOut || cycles + 1 != 17)
            $display("[TB] FAIL b2b_spacing: got %0d expected 17", cycles + 1);
        else passCount++;
        checkCount++;
        if (bus.p !== 32'h0001_0000) $display("[TB] FAIL b2b_second_p: got %h expected 00010000", bus.p);
        else passCount++;
`ifdef MULT_OVF_EN
        checkCount++;
        if (bus.ovf !== 1'b1) $display("[TB] FAIL b2b_ovf: got %b expected 1", bus.ovf);
        else passCount++;
`endif
        @(posedge clk); #1;
        checkCount++;
        if (bus.done !== 1'b0 || bus.p !== 32'h0001_0000)
            $display("[TB] FAIL b2b_hold: got done=%b p=%h expected done=0 p=00010000", bus.done, bus.p);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_carry();
        test_reset_midrun();
        test_start_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mult16_seq_ctrl.md
# mult16_seq_ctrl

Sequential 16x16 unsigned multiplier controller that time-multiplexes one `unsigned_add` instance (16-bit, carry-in/carry-out) over 16 shift-and-add iterations to produce a 32-bit product. It sits beside the single-cycle datapath as a multi-cycle functional unit. It accepts operands on a start pulse, reports busy, and returns the product with a one-cycle done strobe.

## Interface
- No parameters. Width is fixed at 16 to match `unsigned_add`.
- `CLK` in 1: rising-edge clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: request. Sampled only in IDLE or DONE state.
- `A` in 16: multiplicand. Captured on the accepting edge.
- `B` in 16: multiplier. Captured on the accepting edge.
- `BUSY` out 1: high while in RUN state.
- `DONE` out 1: one-cycle strobe. High while in DONE state.
- `P` out 32: product register. Updated only on entry to DONE, held otherwise.
- `OVF` out 1: present only with `MULT_OVF_EN` (see Configuration).

## Operation
- Internal registers:
  - `M[15:0]`: multiplicand.
  - `HI[15:0]`, `LO[15:0]`: accumulator and shifting multiplier.
  - `CNT[4:0]`: iteration counter.
  - `STATE` (2 bits).
- States:
  - IDLE: waits for START.
  - RUN: iterates.
  - DONE: strobes the result.
- IDLE/DONE with `START`=1: `M`←A, `HI`←0, `LO`←B, `CNT`←0, go to RUN.
- DONE with `START`=0: go to IDLE.
- Single `unsigned_add` instance, wired as: A=`HI`, B=(`LO[0]` ? `M` : 16'h0000), Cin=0. Outputs are `SUM` and `C`.
- RUN, each edge:
  - {`HI`,`LO`} ← {C, SUM, `LO[15:1]`}, a 33-bit right shift that keeps the carry.
  - `CNT`←`CNT`+1.
  - When `CNT`==15, also set `P`←{C, SUM, `LO[15:1]`} and go to DONE.
- `START` asserted in RUN is ignored. It is neither queued nor an error.
- Operand changes on `A`/`B` after capture have no effect.
- Zero operands still take the full 16 iterations. There is no early exit.
- Carry out of bit 15 is never lost. The maximum case 16'hFFFF × 16'hFFFF = 32'hFFFE0001.
- Reset, asserted at any time including mid-RUN:
  - Immediately forces IDLE.
  - `BUSY`=0, `DONE`=0, `P`=0, `OVF`=0.
  - `M`/`HI`/`LO`/`CNT`=0.
  - Any in-flight result is discarded.

## Timing
- START accepted at edge k. `BUSY`=1 from after k through edge k+16.
- Iterations occur at edges k+1 through k+16. `P` is valid and `DONE`=1 after edge k+16.
- Latency from START to DONE is 16 cycles.
- `DONE` is high for exactly one cycle. `BUSY` and `DONE` are never high together.
- Back-to-back operation:
  - `START` held high in the DONE cycle is accepted at edge k+17.
  - `BUSY` rises after k+17, and the next DONE follows after k+33.
  - Throughput is one product per 17 cycles.
- `P` retains its last value through IDLE and RUN until the next DONE entry.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MULT_OVF_EN` defined:
  - Adds port `OVF` out 1.
  - `OVF` is loaded together with `P`, with value `OVF`←(|product[31:16]).
  - `OVF` flags a product that does not fit in 16 bits.
  - Held with `P`; reset value 0.
- `MULT_OVF_EN` undefined: `OVF` port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset mid-RUN:
  - Stimulus: start 16'h1234×16'h5678, then pull `RST_N` low at iteration 7.
  - Required: outputs go to 0 asynchronously, state is IDLE, no DONE follows.
  - After release, 3×5 yields `P`=32'h0000000F.
- Basic product:
  - Stimulus: A=16'h0003, B=16'h0005, START one cycle.
  - Required: `BUSY` high 16 cycles, then `DONE` one cycle with `P`=32'h0000000F, `OVF`=0.
- Carry path:
  - Stimulus: A=16'hFFFF, B=16'hFFFF.
  - Required: `P`=32'hFFFE0001, `OVF`=1 (with `MULT_OVF_EN`).
- Zero operand:
  - Stimulus: A=16'h0000, B=16'hABCD.
  - Required: still 16 BUSY cycles, then `P`=0 and `OVF`=0.
- START while busy:
  - Stimulus: start 16'h0100×16'h0100, and pulse START with A=B=16'h0001 at iteration 5.
  - Required: the second request is ignored, `P`=32'h00010000, `OVF`=1.
- Back-to-back:
  - Stimulus: hold START high with 16'h0002×16'h0007, then 16'h8000×16'h0002.
  - Required: first DONE gives `P`=32'h0000000E. The second request is accepted in the DONE cycle, and its DONE arrives exactly 17 cycles after the first with `P`=32'h00010000.
